// File: rtl/keypad_pkg.sv
// Shared definitions for the calculator keypad scanner: key indices, operator
// codes, event-FSM states and small frame helpers.
package keypad_pkg;

  localparam int NUM_ROWS = 5;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef logic [NUM_KEYS-1:0] frame_t;
  typedef logic [4:0]          key_idx_t;

  localparam key_idx_t K_0    = 5'd0;
  localparam key_idx_t K_1    = 5'd1;
  localparam key_idx_t K_2    = 5'd2;
  localparam key_idx_t K_3    = 5'd3;
  localparam key_idx_t K_4    = 5'd4;
  localparam key_idx_t K_5    = 5'd5;
  localparam key_idx_t K_6    = 5'd6;
  localparam key_idx_t K_7    = 5'd7;
  localparam key_idx_t K_8    = 5'd8;
  localparam key_idx_t K_9    = 5'd9;
  localparam key_idx_t K_ADD  = 5'd10;
  localparam key_idx_t K_SUB  = 5'd11;
  localparam key_idx_t K_MUL  = 5'd12;
  localparam key_idx_t K_DIV  = 5'd13;
  localparam key_idx_t K_EQ   = 5'd14;
  localparam key_idx_t K_BKSP = 5'd15;
  localparam key_idx_t K_CLR  = 5'd16;
  localparam key_idx_t K_MS   = 5'd17;
  localparam key_idx_t K_MR   = 5'd18;
  localparam key_idx_t K_MC   = 5'd19;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LOCKED  = 2'd2
  } kp_state_e;

  typedef struct packed {
    logic dig;
    logic op;
    logic sub;
    logic ex;
    logic bksp;
    logic clr;
    logic ms;
    logic mr;
    logic mc;
  } key_pulse_t;

  // Index of the lowest set key; only meaningful when exactly one key is set.
  function automatic key_idx_t key_index(frame_t f);
    key_idx_t idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (f[i]) idx = key_idx_t'(i);
    return idx;
  endfunction

  // Number of keys down, saturating at 2 ("two or more").
  function automatic logic [1:0] key_count(frame_t f);
    logic [1:0] n;
    n = 2'd0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (f[i] && n != 2'd2) n = n + 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key-event bundle between the scanner (master) and the
// calculator control logic / matrix model (slave).
interface keypad_scanner_if;
  logic [3:0] col_out;
  logic [4:0] row_in;
  logic       key_dig;
  logic       key_op;
  logic       key_sub;
  logic       key_ex;
  logic       key_bksp;
  logic       key_clr;
  logic       key_ms;
  logic       key_mr;
  logic       key_mc;
  logic [3:0] digit;
  logic [1:0] op_code;

  modport master (
    output col_out, key_dig, key_op, key_sub, key_ex, key_bksp, key_clr,
           key_ms, key_mr, key_mc, digit, op_code,
    input  row_in
  );

  modport slave (
    input  col_out, key_dig, key_op, key_sub, key_ex, key_bksp, key_clr,
           key_ms, key_mr, key_mc, digit, op_code,
    output row_in
  );
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: the debounced frame follows the scanned frame once it
// has repeated unchanged for DEBOUNCE_SCANS consecutive frames.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  frame_t frame_i,
  input  logic   frame_vld_i,
  output frame_t deb_frame_o,
  output logic   deb_vld_o
);

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  frame_t        prev_q, prev_d;
  frame_t        deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;

  always_comb begin
    prev_d = prev_q;
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    vld_d  = 1'b0;
    if (frame_vld_i) begin
      prev_d = frame_i;
      if (frame_i == prev_q)
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      else
        cnt_d = '0;
      // Strobes every frame while stable so downstream can count frames held.
      if (cnt_d == CNT_MAX) begin
        deb_d = frame_i;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      deb_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  assign deb_frame_o = deb_q;
  assign deb_vld_o   = vld_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x5 calculator keypad scanner: column scan, row synchronizer, debounce and
// one-pulse-per-press event decode. Define KEYPAD_REPEAT_EN for BKSP auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES          = 1000,
  parameter int DEBOUNCE_SCANS       = 4,
  parameter int REPEAT_DELAY_FRAMES  = 50,
  parameter int REPEAT_PERIOD_FRAMES = 10
) (
  input  logic clock,
  input  logic reset,
  keypad_scanner_if.master kp
);

  localparam int            DW         = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

  logic [NUM_ROWS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [1:0]          col_q, col_d;
  frame_t              frame_q, frame_d;
  logic                frame_vld;
  frame_t              deb_frame;
  logic                deb_vld;

  kp_state_e  state_q, state_d;
  logic [1:0] key_cnt;
  key_idx_t   key_idx;
  logic [4:0] op_off;
  logic       press_fire;
  logic       rep_fire;
  key_pulse_t pulse_q, pulse_d;
  logic [3:0] digit_q, digit_d;
  logic [1:0] op_code_q, op_code_d;

  // The debouncer sees the completed frame on the same edge it is captured.
  always_comb begin
    sync1_d   = kp.row_in;
    sync2_d   = sync1_q;
    dwell_d   = dwell_q + 1'b1;
    col_d     = col_q;
    frame_d   = frame_q;
    frame_vld = 1'b0;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      col_d   = col_q + 2'd1;
      for (int r = 0; r < NUM_ROWS; r++)
        frame_d[r*NUM_COLS + int'(col_q)] = ~sync2_q[r];
      frame_vld = (col_q == 2'd3);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dwell_q <= '0;
      col_q   <= '0;
      frame_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dwell_q <= dwell_d;
      col_q   <= col_d;
      frame_q <= frame_d;
    end
  end

  assign kp.col_out = ~(4'b0001 << col_q);

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clock       (clock),
    .reset       (reset),
    .frame_i     (frame_d),
    .frame_vld_i (frame_vld),
    .deb_frame_o (deb_frame),
    .deb_vld_o   (deb_vld)
  );

  assign key_cnt = key_count(deb_frame);
  assign key_idx = key_index(deb_frame);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Only a full release returns to IDLE, so a new press needs an empty frame first.
  always_comb begin
    state_d = state_q;
    if (deb_vld) begin
      if (key_cnt == 2'd0)
        state_d = ST_IDLE;
      else begin
        case (state_q)
          ST_IDLE:    state_d = (key_cnt == 2'd1) ? ST_PRESSED : ST_LOCKED;
          ST_PRESSED: state_d = (key_cnt == 2'd1) ? ST_PRESSED : ST_LOCKED;
          default:    state_d = ST_LOCKED;
        endcase
      end
    end
  end

  always_comb begin
    pulse_d    = '0;
    digit_d    = digit_q;
    op_code_d  = op_code_q;
    op_off     = key_idx - K_ADD;
    press_fire = deb_vld && (state_q == ST_IDLE) && (key_cnt == 2'd1);
    if (press_fire) begin
      if (key_idx <= K_9) begin
        pulse_d.dig = 1'b1;
        digit_d     = key_idx[3:0];
      end else if (key_idx <= K_DIV) begin
        pulse_d.op  = 1'b1;
        pulse_d.sub = (key_idx == K_SUB);
        op_code_d   = op_off[1:0];
      end else begin
        case (key_idx)
          K_EQ:    pulse_d.ex   = 1'b1;
          K_BKSP:  pulse_d.bksp = 1'b1;
          K_CLR:   pulse_d.clr  = 1'b1;
          K_MS:    pulse_d.ms   = 1'b1;
          K_MR:    pulse_d.mr   = 1'b1;
          K_MC:    pulse_d.mc   = 1'b1;
          default: ;
        endcase
      end
    end
    if (rep_fire) pulse_d.bksp = 1'b1;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_FRAMES > REPEAT_PERIOD_FRAMES) ?
                           REPEAT_DELAY_FRAMES : REPEAT_PERIOD_FRAMES;
  localparam int     RW         = $clog2(RPT_MAX + 1);
  localparam frame_t BKSP_FRAME = frame_t'(1) << K_BKSP;

  logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_next;
  logic          rep_late_q, rep_late_d;

  // rep_late marks that the first (long) delay has elapsed.
  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    rep_late_d = rep_late_q;
    rep_fire   = 1'b0;
    rep_next   = rep_cnt_q + 1'b1;
    if (state_d != ST_PRESSED || (deb_vld && deb_frame != BKSP_FRAME)) begin
      rep_cnt_d  = '0;
      rep_late_d = 1'b0;
    end else if (deb_vld && state_q == ST_PRESSED) begin
      if (rep_next == (rep_late_q ? RW'(REPEAT_PERIOD_FRAMES) : RW'(REPEAT_DELAY_FRAMES))) begin
        rep_fire   = 1'b1;
        rep_cnt_d  = '0;
        rep_late_d = 1'b1;
      end else begin
        rep_cnt_d = rep_next;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_cnt_q  <= '0;
      rep_late_q <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      rep_late_q <= rep_late_d;
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY_FRAMES + REPEAT_PERIOD_FRAMES;
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_q   <= '0;
      digit_q   <= '0;
      op_code_q <= OP_ADD;
    end else begin
      pulse_q   <= pulse_d;
      digit_q   <= digit_d;
      op_code_q <= op_code_d;
    end
  end

  assign kp.key_dig  = pulse_q.dig;
  assign kp.key_op   = pulse_q.op;
  assign kp.key_sub  = pulse_q.sub;
  assign kp.key_ex   = pulse_q.ex;
  assign kp.key_bksp = pulse_q.bksp;
  assign kp.key_clr  = pulse_q.clr;
  assign kp.key_ms   = pulse_q.ms;
  assign kp.key_mr   = pulse_q.mr;
  assign kp.key_mc   = pulse_q.mc;
  assign kp.digit    = digit_q;
  assign kp.op_code  = op_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_SCANS=2:
// per-key table plus bounce, rollover, reset and BKSP-repeat sequences.
module tb_keypad_scanner;

  localparam int SCAN  = 4;
  localparam int FRAME = 4 * SCAN;

  // Pulse-count slots: 0 dig 1 op 2 sub 3 ex 4 bksp 5 clr 6 ms 7 mr 8 mc,
  // 9 op+sub in same cycle, 10 cycles with an illegal pulse combination.
  localparam logic [9:0] M_DIG  = 10'h001;
  localparam logic [9:0] M_OP   = 10'h002;
  localparam logic [9:0] M_SUB  = 10'h004;
  localparam logic [9:0] M_EX   = 10'h008;
  localparam logic [9:0] M_BKSP = 10'h010;
  localparam logic [9:0] M_CLR  = 10'h020;
  localparam logic [9:0] M_MS   = 10'h040;
  localparam logic [9:0] M_MR   = 10'h080;
  localparam logic [9:0] M_MC   = 10'h100;
  localparam logic [9:0] M_TOG  = 10'h200;

  typedef struct {
    logic [4:0] key;
    logic [9:0] mask;
    logic [3:0] digit;
    logic [1:0] op;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] pressed = '0;

  int n_checks = 0;
  int n_errors = 0;
  int pc [0:10];
  int cyc = 0;
  int bk_time [0:15];
  int bk_n = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_CYCLES          (SCAN),
    .DEBOUNCE_SCANS       (2),
    .REPEAT_DELAY_FRAMES  (3),
    .REPEAT_PERIOD_FRAMES (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kif)
  );

  always #5 clock = ~clock;

  // Passive matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    kif.row_in = '1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.col_out[c] && pressed[r*4+c]) kif.row_in[r] = 1'b0;
  end

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (kif.key_dig)  pc[0] <= pc[0] + 1;
    if (kif.key_op)   pc[1] <= pc[1] + 1;
    if (kif.key_sub)  pc[2] <= pc[2] + 1;
    if (kif.key_ex)   pc[3] <= pc[3] + 1;
    if (kif.key_bksp) pc[4] <= pc[4] + 1;
    if (kif.key_clr)  pc[5] <= pc[5] + 1;
    if (kif.key_ms)   pc[6] <= pc[6] + 1;
    if (kif.key_mr)   pc[7] <= pc[7] + 1;
    if (kif.key_mc)   pc[8] <= pc[8] + 1;
    if (kif.key_op && kif.key_sub) pc[9] <= pc[9] + 1;
    if ((int'(kif.key_dig) + int'(kif.key_op) + int'(kif.key_ex) + int'(kif.key_bksp) +
         int'(kif.key_clr) + int'(kif.key_ms) + int'(kif.key_mr) + int'(kif.key_mc)) > 1 ||
        (kif.key_sub && !kif.key_op))
      pc[10] <= pc[10] + 1;
    if (kif.key_bksp) begin
      bk_time[bk_n % 16] <= cyc;
      bk_n <= bk_n + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
  endtask

  function automatic logic [8:0] pulses_now();
    return {kif.key_dig, kif.key_op, kif.key_sub, kif.key_ex, kif.key_bksp,
            kif.key_clr, kif.key_ms, kif.key_mr, kif.key_mc};
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t        vecs [14];
    int          base [0:9];
    logic [63:0] act, exp;
    int          b, bn, w;

    vecs[0]  = '{5'd7,  M_DIG,               4'd7, 2'b00};
    vecs[1]  = '{5'd0,  M_DIG,               4'd0, 2'b00};
    vecs[2]  = '{5'd9,  M_DIG,               4'd9, 2'b00};
    vecs[3]  = '{5'd10, M_OP,                4'd9, 2'b00};
    vecs[4]  = '{5'd11, M_OP | M_SUB | M_TOG, 4'd9, 2'b01};
    vecs[5]  = '{5'd12, M_OP,                4'd9, 2'b10};
    vecs[6]  = '{5'd13, M_OP,                4'd9, 2'b11};
    vecs[7]  = '{5'd14, M_EX,                4'd9, 2'b11};
    vecs[8]  = '{5'd15, M_BKSP,              4'd9, 2'b11};
    vecs[9]  = '{5'd16, M_CLR,               4'd9, 2'b11};
    vecs[10] = '{5'd17, M_MS,                4'd9, 2'b11};
    vecs[11] = '{5'd18, M_MR,                4'd9, 2'b11};
    vecs[12] = '{5'd19, M_MC,                4'd9, 2'b11};
    vecs[13] = '{5'd8,  M_DIG,               4'd8, 2'b11};

    // Reset state
    wait_cycles(3);
    @(negedge clock);
    check("reset_col_out", kif.col_out, 4'b1110);
    check("reset_pulses", pulses_now(), 9'd0);
    check("reset_digit", kif.digit, 4'd0);
    check("reset_op_code", kif.op_code, 2'b00);
    reset = 1'b0;

    // One clean press per key; held 5 frames so no auto-repeat can occur.
    for (int v = 0; v < 14; v++) begin
      for (int i = 0; i < 10; i++) base[i] = pc[i];
      pressed = 20'd1 << vecs[v].key;
      wait_cycles(5 * FRAME);
      pressed = '0;
      wait_cycles(5 * FRAME);
      @(negedge clock);
      act = '0;
      exp = '0;
      for (int i = 0; i < 10; i++) begin
        act = act | (64'((pc[i] - base[i]) & 15) << (4 * i));
        exp = exp | (64'(vecs[v].mask[i]) << (4 * i));
      end
      check($sformatf("k%0d_pulses", vecs[v].key), act, exp);
      check($sformatf("k%0d_digit", vecs[v].key), kif.digit, vecs[v].digit);
      check($sformatf("k%0d_op_code", vecs[v].key), kif.op_code, vecs[v].op);
    end

    // k3 bouncing once per frame, then settling
    b = pc[0];
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? 20'h00008 : 20'h00000;
      wait_cycles(FRAME);
    end
    check("bounce_no_pulse", 64'(pc[0] - b), 64'd0);
    pressed = 20'h00008;
    w = 0;
    while (pc[0] == b && w < 3 * FRAME + 8) begin
      @(negedge clock);
      w++;
    end
    check("bounce_settle_in_time", 64'(w < 3 * FRAME + 8), 64'd1);
    wait_cycles(2 * FRAME);
    pressed = '0;
    wait_cycles(5 * FRAME);
    @(negedge clock);
    check("bounce_single_pulse", 64'(pc[0] - b), 64'd1);
    check("bounce_digit", kif.digit, 4'd3);

    // Rollover: k2, then k2+k5, then k5 alone, then release
    b = pc[0];
    pressed = 20'h00004;
    wait_cycles(5 * FRAME);
    pressed = 20'h00024;
    wait_cycles(4 * FRAME);
    pressed = 20'h00020;
    wait_cycles(4 * FRAME);
    pressed = '0;
    wait_cycles(5 * FRAME);
    @(negedge clock);
    check("rollover_dig_count", 64'(pc[0] - b), 64'd1);
    check("rollover_digit", kif.digit, 4'd2);

    // Reset in the middle of a held '=' press
    b = pc[3];
    pressed = 20'd1 << 14;
    wait_cycles(5 * FRAME);
    @(negedge clock);
    check("eq_before_reset", 64'(pc[3] - b), 64'd1);
    w = 0;
    while (kif.col_out != 4'b1011 && w < FRAME) begin
      @(negedge clock);
      w++;
    end
    check("scan_reaches_col2", 64'(w < FRAME), 64'd1);
    reset = 1'b1;
    #1;
    check("midreset_col_out", kif.col_out, 4'b1110);
    check("midreset_digit", kif.digit, 4'd0);
    check("midreset_op_code", kif.op_code, 2'b00);
    wait_cycles(2);
    @(negedge clock);
    check("midreset_pulses", pulses_now(), 9'd0);
    reset = 1'b0;
    b = pc[3];
    wait_cycles(6 * FRAME);
    @(negedge clock);
    check("eq_after_reset", 64'(pc[3] - b), 64'd1);
    pressed = '0;
    wait_cycles(5 * FRAME);

    // BKSP held long enough to cover the press and +7 frames of debounced updates
    b  = pc[4];
    bn = bk_n;
    pressed = 20'd1 << 15;
    wait_cycles(11 * FRAME);
    pressed = '0;
    wait_cycles(5 * FRAME);
    @(negedge clock);
`ifdef KEYPAD_REPEAT_EN
    check("bksp_repeat_count", 64'(pc[4] - b), 64'd4);
    check("bksp_gap_first", 64'(bk_time[(bn + 1) % 16] - bk_time[bn % 16]), 64'(3 * FRAME));
    check("bksp_gap_second", 64'(bk_time[(bn + 2) % 16] - bk_time[(bn + 1) % 16]), 64'(2 * FRAME));
    check("bksp_gap_third", 64'(bk_time[(bn + 3) % 16] - bk_time[(bn + 2) % 16]), 64'(2 * FRAME));
`else
    check("bksp_single_pulse", 64'(pc[4] - b), 64'd1);
`endif

    check("single_category_per_cycle", 64'(pc[10]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
